// File: rtl/fb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_arbiter                                                               |
// | Single-port framebuffer RAM arbiter: scan-out read > clear fill >        |
// | round-robin writers (renderer w0, CPU w1).                               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fb_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              display_on,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              w0_valid,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  output logic              w0_ready,
  input  logic              w1_valid,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  output logic              w1_ready,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_color;
  logic              r_last;    // 1: port 1 was served last
  logic              r_rd_p1;

  logic w_rd_gnt;
  logic w_clr_wr;
  logic w_wr_ok;
  logic w_gnt0;
  logic w_gnt1;

  assign w_rd_gnt = rd_req & display_on;
  assign w_clr_wr = (r_state == S_CLEAR) & ~w_rd_gnt;
  // A clear request in IDLE claims the cycle from the writers.
  assign w_wr_ok  = (r_state == S_IDLE) & ~clear_start & ~w_rd_gnt;
  assign w_gnt0   = w_wr_ok & w0_valid & (~w1_valid | r_last);
  assign w_gnt1   = w_wr_ok & w1_valid & (~w0_valid | ~r_last);

  assign w0_ready = w_gnt0;
  assign w1_ready = w_gnt1;

  // RAM data lands one cycle after the command, in the same cycle as rd_valid.
  assign rd_data  = rd_valid ? ram_q : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_color    <= '0;
      r_last     <= 1'b1;
      r_rd_p1    <= 1'b0;
      rd_valid   <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_d      <= '0;
    end else begin
      r_rd_p1    <= w_rd_gnt;
      rd_valid   <= r_rd_p1;
      clear_done <= 1'b0;
      ram_we     <= 1'b0;

      if (w_rd_gnt) begin
        ram_addr <= rd_addr;
      end else if (w_clr_wr) begin
        ram_we   <= 1'b1;
        ram_addr <= r_cnt;
        ram_d    <= r_color;
        r_cnt    <= r_cnt + 1'b1;
        if (r_cnt == C_LAST_ADDR) begin
          r_state    <= S_IDLE;
          clear_busy <= 1'b0;
          clear_done <= 1'b1;
        end
      end else if (w_gnt0) begin
        ram_we   <= 1'b1;
        ram_addr <= w0_addr;
        ram_d    <= w0_data;
        r_last   <= 1'b0;
      end else if (w_gnt1) begin
        ram_we   <= 1'b1;
        ram_addr <= w1_addr;
        ram_d    <= w1_data;
        r_last   <= 1'b1;
      end

      if ((r_state == S_IDLE) && clear_start) begin
        r_state    <= S_CLEAR;
        clear_busy <= 1'b1;
        r_cnt      <= '0;
        r_color    <= clear_color;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fb_arbiter                                                            |
// | Directed bench for fb_arbiter with a synchronous-read RAM stub.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fb_arbiter;

  logic        clk;
  logic        reset;
  logic        display_on;
  logic        rd_req;
  logic [11:0] rd_addr;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        w0_valid;
  logic [11:0] w0_addr;
  logic [7:0]  w0_data;
  logic        w0_ready;
  logic        w1_valid;
  logic [11:0] w1_addr;
  logic [7:0]  w1_data;
  logic        w1_ready;
  logic        clear_start;
  logic [7:0]  clear_color;
  logic        clear_busy;
  logic        clear_done;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q;

  int checks   = 0;
  int failures = 0;

  fb_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .display_on(display_on),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .w0_valid(w0_valid), .w0_addr(w0_addr), .w0_data(w0_data), .w0_ready(w0_ready),
    .w1_valid(w1_valid), .w1_addr(w1_addr), .w1_data(w1_data), .w1_ready(w1_ready),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM stub: read data is a fixed function of the address, one cycle late.
  always @(posedge clk) ram_q <= ram_addr[7:0] ^ 8'hA5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ram_we"},   32'(ram_we),     32'h0);
    chk({tag, "_ram_addr"}, 32'(ram_addr),   32'h0);
    chk({tag, "_ram_d"},    32'(ram_d),      32'h0);
    chk({tag, "_rd_valid"}, 32'(rd_valid),   32'h0);
    chk({tag, "_rd_data"},  32'(rd_data),    32'h0);
    chk({tag, "_busy"},     32'(clear_busy), 32'h0);
    chk({tag, "_done"},     32'(clear_done), 32'h0);
  endtask

  initial begin : stim
    logic [11:0] exp_addr;
    int nwr, nbusy, ndone, bad, rdy_bad, nrd, done_ok, w1_at_done, w0_at_done, junk;

    reset = 1'b1; display_on = 1'b0; rd_req = 1'b0; rd_addr = '0;
    w0_valid = 1'b0; w0_addr = '0; w0_data = '0;
    w1_valid = 1'b0; w1_addr = '0; w1_data = '0;
    clear_start = 1'b0; clear_color = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");

    // Round robin: both writers valid, port 0 wins first tie.
    @(posedge clk); #2;
    reset = 1'b0;
    w0_valid = 1'b1; w0_addr = 12'h010; w0_data = 8'h11;
    w1_valid = 1'b1; w1_addr = 12'h020; w1_data = 8'h22;
    @(negedge clk);
    chk("rr0_w0_ready", 32'(w0_ready), 32'h1);
    chk("rr0_w1_ready", 32'(w1_ready), 32'h0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #2;
      @(negedge clk);
      chk("rr_w0_ready", 32'(w0_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_w1_ready", 32'(w1_ready), (i % 2 == 1) ? 32'h1 : 32'h0);
      chk("rr_ram_we",   32'(ram_we), 32'h1);
      chk("rr_ram_addr", 32'(ram_addr), (i % 2 == 1) ? 32'h010 : 32'h020);
      chk("rr_ram_d",    32'(ram_d),    (i % 2 == 1) ? 32'h11  : 32'h22);
    end
    // Lone requester w1 wins although port 1 was served last.
    @(posedge clk); #2;
    w0_valid = 1'b0; w1_addr = 12'h021; w1_data = 8'h33;
    @(negedge clk);
    chk("lone_w1_ready", 32'(w1_ready), 32'h1);
    @(posedge clk); #2;
    w0_valid = 1'b1;
    @(negedge clk);
    chk("tie_after_lone_w0", 32'(w0_ready), 32'h1);
    chk("tie_after_lone_w1", 32'(w1_ready), 32'h0);
    chk("lone_ram_addr", 32'(ram_addr), 32'h021);
    chk("lone_ram_d",    32'(ram_d),    32'h33);
    @(posedge clk); #2;
    w0_valid = 1'b0; w1_valid = 1'b0;
    @(negedge clk);
    chk("last_wr_addr", 32'(ram_addr), 32'h010);
    @(posedge clk); #2;
    @(negedge clk);
    chk("idle_we",        32'(ram_we),   32'h0);
    chk("idle_hold_addr", 32'(ram_addr), 32'h010);
    chk("idle_hold_d",    32'(ram_d),    32'h11);

    // Scan-out read beats a writer.
    @(posedge clk); #2;
    display_on = 1'b1; rd_req = 1'b1; rd_addr = 12'h123; w0_valid = 1'b1;
    @(negedge clk);
    chk("rd_w0_ready", 32'(w0_ready), 32'h0);
    @(posedge clk); #2;
    rd_req = 1'b0; w0_valid = 1'b0;
    @(negedge clk);
    chk("rd_n1_addr", 32'(ram_addr), 32'h123);
    chk("rd_n1_we",   32'(ram_we),   32'h0);
    chk("rd_n1_valid", 32'(rd_valid), 32'h0);
    @(posedge clk); #2;
    display_on = 1'b0; rd_req = 1'b1; rd_addr = 12'h456;
    @(negedge clk);
    chk("rd_n2_valid", 32'(rd_valid), 32'h1);
    chk("rd_n2_data",  32'(rd_data),  32'h86);
    @(posedge clk); #2;
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_off_addr",  32'(ram_addr), 32'h123);
    chk("rd_off_valid", 32'(rd_valid), 32'h0);
    chk("rd_off_data",  32'(rd_data),  32'h0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("rd_off_valid2", 32'(rd_valid), 32'h0);

    // Clear 0x5A with both writers pending; restart attempt at counter 0x100.
    @(posedge clk); #2;
    clear_start = 1'b1; clear_color = 8'h5A;
    w0_valid = 1'b1; w0_addr = 12'h0AB; w0_data = 8'hE0;
    w1_valid = 1'b1; w1_addr = 12'h0CD; w1_data = 8'hE1;
    @(negedge clk);
    chk("clr_start_w0", 32'(w0_ready), 32'h0);
    chk("clr_start_w1", 32'(w1_ready), 32'h0);
    exp_addr = '0; nwr = 0; nbusy = 0; ndone = 0; bad = 0; rdy_bad = 0;
    done_ok = 0; w0_at_done = 0; w1_at_done = 0;
    for (int i = 0; i < 4200 && ndone == 0; i++) begin
      @(posedge clk); #2;
      clear_start = (i == 256);
      clear_color = (i == 256) ? 8'hC3 : 8'h5A;
      @(negedge clk);
      if (clear_busy) nbusy++;
      if (clear_busy && (w0_ready || w1_ready)) rdy_bad++;
      if (ram_we) begin
        if (ram_addr !== exp_addr || ram_d !== 8'h5A) bad++;
        exp_addr = exp_addr + 12'd1;
        nwr++;
      end
      if (clear_done) begin
        ndone++;
        if (ram_addr === 12'hFFF && ram_we === 1'b1 && clear_busy === 1'b0) done_ok = 1;
        w0_at_done = int'(w0_ready);
        w1_at_done = int'(w1_ready);
      end
    end
    chk("clr1_writes",  nwr,     32'd4096);
    chk("clr1_badwr",   bad,     32'd0);
    chk("clr1_busy",    nbusy,   32'd4096);
    chk("clr1_done",    ndone,   32'd1);
    chk("clr1_done_ok", done_ok, 32'd1);
    chk("clr1_rdy",     rdy_bad, 32'd0);
    chk("clr1_ptr_w0",  w0_at_done, 32'd0);
    chk("clr1_ptr_w1",  w1_at_done, 32'd1);
    @(posedge clk); #2;
    w0_valid = 1'b0; w1_valid = 1'b0;
    @(negedge clk);
    chk("post_clr_addr", 32'(ram_addr), 32'h0CD);
    chk("post_clr_d",    32'(ram_d),    32'hE1);

    // Clear 0x3C with ten scan-out reads stealing cycles.
    @(posedge clk); #2;
    clear_start = 1'b1; clear_color = 8'h3C; display_on = 1'b1; rd_addr = 12'h0AA;
    @(negedge clk);
    exp_addr = '0; nwr = 0; nbusy = 0; ndone = 0; bad = 0; nrd = 0;
    for (int i = 0; i < 4300 && ndone == 0; i++) begin
      @(posedge clk); #2;
      clear_start = 1'b0;
      rd_req = (i >= 10 && i <= 100 && i % 10 == 0);
      @(negedge clk);
      if (clear_busy) nbusy++;
      if (rd_valid) nrd++;
      if (ram_we) begin
        if (ram_addr !== exp_addr || ram_d !== 8'h3C) bad++;
        exp_addr = exp_addr + 12'd1;
        nwr++;
      end
      if (clear_done) ndone++;
    end
    chk("clr2_writes", nwr,   32'd4096);
    chk("clr2_badwr",  bad,   32'd0);
    chk("clr2_busy",   nbusy, 32'd4106);
    chk("clr2_done",   ndone, 32'd1);
    chk("clr2_reads",  nrd,   32'd10);

    // Clear 0x77, reset at counter 0x800 with a read in flight.
    @(posedge clk); #2;
    rd_req = 1'b0; clear_start = 1'b1; clear_color = 8'h77; rd_addr = 12'h555;
    @(negedge clk);
    for (int i = 0; i < 2050; i++) begin
      @(posedge clk); #2;
      clear_start = 1'b0;
      rd_req = (i == 2048);
      @(negedge clk);
      if (i == 2048) chk("clr3_at7ff", 32'(ram_addr), 32'h7FF);
      if (i == 2049) chk("clr3_rd_addr", 32'(ram_addr), 32'h555);
    end
    #1 reset = 1'b1;
    #1 chk_reset_vals("abort");
    @(posedge clk); #2;
    reset = 1'b0; rd_req = 1'b0;
    junk = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rd_valid || clear_done || ram_we || clear_busy) junk++;
      @(posedge clk); #2;
    end
    chk("abort_quiet", junk, 32'd0);
    clear_start = 1'b1; clear_color = 8'h99;
    @(posedge clk); #2;
    clear_start = 1'b0;
    @(negedge clk);
    chk("restart_busy", 32'(clear_busy), 32'h1);
    @(posedge clk); #2;
    @(negedge clk);
    chk("restart_we",   32'(ram_we),   32'h1);
    chk("restart_addr", 32'(ram_addr), 32'h000);
    chk("restart_d",    32'(ram_d),    32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, framebuffer address width.
REQ-002 Parameter DATA_W, default 8, framebuffer data width.
REQ-003 clk  input  1  system clock, all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 display_on  input  1  high during visible scan-out.
REQ-006 rd_req / rd_addr  input  1 / ADDR_W  scan-out read request and address.
REQ-007 rd_valid / rd_data  output  1 / DATA_W  scan-out read response.
REQ-008 w0_valid, w0_addr, w0_data / w0_ready  in, in, in / out  1, ADDR_W, DATA_W / 1  renderer write port.
REQ-009 w1_valid, w1_addr, w1_data / w1_ready  in, in, in / out  1, ADDR_W, DATA_W / 1  CPU write port.
REQ-010 clear_start / clear_color  input  1 / DATA_W  start a full-buffer fill with clear_color.
REQ-011 clear_busy / clear_done  output  1 / 1  fill in progress / one-cycle completion pulse.
REQ-012 ram_we, ram_addr, ram_d  output  1, ADDR_W, DATA_W  single-port synchronous RAM command, registered.
REQ-013 ram_q  input  DATA_W  RAM read data, valid one cycle after the read command appears on ram_addr.

Function
REQ-014 The block SHALL issue at most one RAM operation per cycle, chosen by fixed priority: scan-out read > clear > writers.
REQ-015 A scan-out read SHALL be granted in any cycle with rd_req=1 and display_on=1; rd_req with display_on=0 SHALL be ignored.
REQ-016 A read granted in cycle N SHALL drive ram_addr=rd_addr, ram_we=0 in cycle N+1 and assert rd_valid=1 with rd_data=ram_q in cycle N+2.
REQ-017 wX_ready SHALL be combinational and high only in a cycle where port X is granted; a write transfers when wX_valid and wX_ready are both high.
REQ-018 A write accepted in cycle N SHALL appear as ram_we=1, ram_addr=wX_addr, ram_d=wX_data in cycle N+1 only.
REQ-019 Writer arbitration SHALL be round-robin: a 1-bit last-served pointer, updated only on a writer grant; with both valid, the port not last served wins; a lone requester wins regardless of pointer.
REQ-020 States: IDLE, CLEAR; IDLE->CLEAR on clear_start; CLEAR->IDLE after the write to address 2^ADDR_W-1 is issued.
REQ-021 On entering CLEAR, clear_color SHALL be latched and an ADDR_W-bit counter set to 0; clear_busy SHALL be high throughout CLEAR.
REQ-022 In CLEAR, each cycle not taken by a scan-out read SHALL issue one write (latched color, counter address) and increment the counter; read-taken cycles leave the counter unchanged.
REQ-023 w0_ready and w1_ready SHALL be 0 throughout CLEAR; the round-robin pointer SHALL hold.
REQ-024 clear_done SHALL pulse high for exactly the cycle in which the final clear write is driven on the RAM port (ram_addr=2^ADDR_W-1); clear_busy deasserts in the same cycle.
REQ-025 clear_start while in CLEAR SHALL be ignored (no restart, no color change).
REQ-026 clear_start in the same cycle as writer requests SHALL win: no writer is granted that cycle; a scan-out read in that cycle is still granted.
REQ-027 In cycles with no grant, ram_we SHALL be 0; ram_addr and ram_d SHALL hold their previous values.

Reset
REQ-028 Reset SHALL force state IDLE, counter 0, pointer = port 1 last served (port 0 wins first tie), ram_we=0, ram_addr=0, ram_d=0, rd_valid=0, rd_data=0, clear_busy=0, clear_done=0.
REQ-029 Reset during CLEAR SHALL abort the fill with no clear_done pulse; in-flight reads SHALL not produce rd_valid.

Verification
REQ-030 Both writers valid continuously, no reads -> grants alternate 0,1,0,1; ram_we=1 every cycle from the cycle after the first grant.
REQ-031 display_on=1, rd_req=1 at rd_addr=0x123, w0_valid=1 -> w0_ready=0; ram_addr=0x123, ram_we=0 at N+1; rd_valid=1, rd_data=ram_q at N+2.
REQ-032 clear_start with clear_color=0x5A, no reads -> 4096 consecutive writes of 0x5A to 0x000..0xFFF; clear_done pulses with ram_addr=0xFFF; clear_busy high 4096 cycles.
REQ-033 Clear with rd_req granted in 10 of the cycles -> fill completes in exactly 4106 cycles, no address skipped or repeated.
REQ-034 reset asserted at counter=0x800 -> outputs at reset values; a subsequent clear_start restarts at address 0x000.
REQ-035 clear_start pulsed again at counter=0x100 with a new color -> ignored; the fill continues with the original color.
